alu_rr_scheduler: RTL and testbench
===================================

Name: alu_rr_scheduler

Overview:
- Shares one `alu` instance (alu_op_i / a_i / b_i -> result_o / flag_o) between NUM_REQ requesters using round-robin arbitration.
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- One operation is in flight at a time; operands and result are registered around the combinational ALU.
- Sits between board-level or core-level clients (switch sampler, test sequencer, future CPU datapath) and the ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 32, operand/result width; must match alu.
- OP_WIDTH, 5, ALU opcode width (alu_opcodes_pkg encoding).

Ports:
- clk_i  in  1  clock.
- arstn_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester request accept; one-hot or zero.
- req_op_i  in  NUM_REQ*OP_WIDTH  flattened opcodes; requester k uses slice k.
- req_a_i  in  NUM_REQ*DATA_WIDTH  flattened operand A.
- req_b_i  in  NUM_REQ*DATA_WIDTH  flattened operand B.
- rsp_valid_o  out  NUM_REQ  per-requester response valid; one-hot or zero.
- rsp_ready_i  in  NUM_REQ  per-requester response accept.
- rsp_result_o  out  DATA_WIDTH  registered result, shared by all requesters.
- rsp_flag_o  out  1  registered ALU flag.
- busy_o  out  1  high whenever state != IDLE.
- done_cnt_o  out  16  completed-operation counter; wraps at 0xFFFF -> 0.

Behaviour:
- Reset: state=IDLE, rr_ptr=0, operand/op/owner regs=0, rsp_result_o=0, rsp_flag_o=0, req_ready_o=0, rsp_valid_o=0, busy_o=0, done_cnt_o=0. Reset asserted in any state returns all of these immediately.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Winner = first requester with req_valid_i set, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - If a winner exists: req_ready_o[winner]=1 for that cycle (combinational, Mealy). Capture its op/a/b into registers and record owner=winner. Next state EXEC.
  - If no requester is valid: req_ready_o=0 and the FSM stays in IDLE.
- EXEC: ALU is driven from the captured registers. Its result/flag are registered into rsp_result_o/rsp_flag_o. Next state RESP.
- RESP:
  - rsp_valid_o[owner]=1; result and flag are held stable.
  - When rsp_ready_i[owner]=1: the transfer completes, done_cnt_o increments, rr_ptr=(owner+1) mod NUM_REQ, next state IDLE.
  - rsp_ready_i of non-owners is ignored.
- Latency: request accepted in cycle T; rsp_valid_o rises in T+2. Minimum issue interval is 3 cycles, since a new grant is only possible in IDLE.
- req_ready_o is 0 in EXEC and RESP. Requests are never accepted while busy.
- A requester may drop req_valid_i before it is granted. No grant is issued to a non-valid requester.
- Opcode values, including illegal ones, pass to the ALU unchanged. Result is whatever the ALU returns.
- Fairness: a requester holding valid continuously is granted within NUM_REQ grants.
- The ALU is not re-evaluated during RESP. Response data must not change while rsp_valid_o is high.

Decomposition:
- alu_sched_pkg: sched_state_e typedef (IDLE, EXEC, RESP) and the done-counter width constant.
- Opcodes come from the existing alu_opcodes_pkg.
- Sub-module rr_arbiter (combinational):
  - Inputs: NUM_REQ request vector and rr_ptr.
  - Outputs: one-hot grant and binary grant index.
- The existing alu is instantiated once inside alu_rr_scheduler.

Test Plan:
- Single request: reset, requester 0 sends ALU_ADD a=7 b=5 at cycle T, rsp_ready_i=1 -> req_ready_o=4'b0001 at T, rsp_valid_o=4'b0001 at T+2, rsp_result_o=12, done_cnt_o=1.
- Round-robin: all four valid continuously with ALU_ADD a=k b=1 -> grants in order 0,1,2,3,0. Requester k receives result k+1; no response goes to a non-owner.
- Response backpressure: requester 2 ALU_SUB a=3 b=5, rsp_ready_i low for 10 cycles -> rsp_valid_o[2] stays high, result 0xFFFFFFFE stable. No new grant until ready; then IDLE.
- Reset mid-op: deassert arstn_i during EXEC -> all outputs 0 in that cycle, rr_ptr=0. After release, a request from requester 3 is granted normally.
- Withdrawn request: requester 1 pulses valid for one cycle while busy, then drops it -> requester 1 is never granted; the sequence continues with other requesters.
- Counter wrap: force 65536 completions (or preload via a bench-only fast path) -> done_cnt_o returns to 0.

Source files
------------

// File: rtl/alu_opcodes_pkg.sv
// ALU opcode encoding shared by the ALU and every client that issues operations.
// Unlisted codes are illegal and produce a zero result.
package alu_opcodes_pkg;

   localparam int unsigned AluOpWidth = 5;

   localparam logic [AluOpWidth-1:0] ALU_ADD  = 5'd0;
   localparam logic [AluOpWidth-1:0] ALU_SUB  = 5'd1;
   localparam logic [AluOpWidth-1:0] ALU_AND  = 5'd2;
   localparam logic [AluOpWidth-1:0] ALU_OR   = 5'd3;
   localparam logic [AluOpWidth-1:0] ALU_XOR  = 5'd4;
   localparam logic [AluOpWidth-1:0] ALU_SLL  = 5'd5;
   localparam logic [AluOpWidth-1:0] ALU_SRL  = 5'd6;
   localparam logic [AluOpWidth-1:0] ALU_SRA  = 5'd7;
   localparam logic [AluOpWidth-1:0] ALU_SLT  = 5'd8;
   localparam logic [AluOpWidth-1:0] ALU_SLTU = 5'd9;

endpackage

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StExec = 2'd1,
      StResp = 2'd2
   } sched_state_e;

   localparam int unsigned DoneCntW = 16;

endpackage

// File: rtl/alu.sv
// Combinational ALU; flag_o reports a zero result.
module alu
   import alu_opcodes_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 5
) (
   input  logic [OP_WIDTH-1:0]   alu_op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  flag_o
);

   localparam int unsigned ShW = $clog2(DATA_WIDTH);

   logic [ShW-1:0] shamt;

   assign shamt = b_i[ShW-1:0];

   always_comb begin
      result_o = '0;
      case (alu_op_i)
         ALU_ADD:  result_o = a_i + b_i;
         ALU_SUB:  result_o = a_i - b_i;
         ALU_AND:  result_o = a_i & b_i;
         ALU_OR:   result_o = a_i | b_i;
         ALU_XOR:  result_o = a_i ^ b_i;
         ALU_SLL:  result_o = a_i << shamt;
         ALU_SRL:  result_o = a_i >> shamt;
         ALU_SRA:  result_o = $signed(a_i) >>> shamt;
         ALU_SLT:  result_o = {{(DATA_WIDTH-1){1'b0}}, $signed(a_i) < $signed(b_i)};
         ALU_SLTU: result_o = {{(DATA_WIDTH-1){1'b0}}, a_i < b_i};
         default:  result_o = '0;
      endcase
   end

   assign flag_o = (result_o == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr_i wins.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IdxW-1:0]    ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IdxW-1:0]    gnt_idx_o,
   output logic               gnt_any_o
);

   always_comb begin
      logic            found;
      logic [IdxW-1:0] k;
      found     = 1'b0;
      k         = '0;
      gnt_o     = '0;
      gnt_idx_o = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k = IdxW'((32'(ptr_i) + i) % NUM_REQ);
         if (!found && req_i[k]) begin
            found     = 1'b1;
            gnt_o[k]  = 1'b1;
            gnt_idx_o = k;
         end
      end
      gnt_any_o = found;
   end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one ALU between NUM_REQ valid/ready clients; one operation in flight,
// operands and result registered around the combinational ALU.
module alu_rr_scheduler
   import alu_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned OP_WIDTH   = 5
) (
   input  logic                            clk_i,
   input  logic                            arstn_i,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   output logic [NUM_REQ-1:0]              req_ready_o,
   input  logic [NUM_REQ*OP_WIDTH-1:0]     req_op_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_a_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_b_i,
   output logic [NUM_REQ-1:0]              rsp_valid_o,
   input  logic [NUM_REQ-1:0]              rsp_ready_i,
   output logic [DATA_WIDTH-1:0]           rsp_result_o,
   output logic                            rsp_flag_o,
   output logic                            busy_o,
   output logic [DoneCntW-1:0]             done_cnt_o
);

   localparam int unsigned IdxW = $clog2(NUM_REQ);

   sched_state_e state_q, state_d;

   logic [IdxW-1:0]       rr_ptr_q, owner_q, gnt_idx, next_ptr;
   logic [NUM_REQ-1:0]    gnt;
   logic                  gnt_any;
   logic                  capture, rsp_fire;
   logic [OP_WIDTH-1:0]   op_q;
   logic [DATA_WIDTH-1:0] a_q, b_q, result_q;
   logic                  flag_q;
   logic [DATA_WIDTH-1:0] alu_result;
   logic                  alu_flag;
   logic [DoneCntW-1:0]   done_cnt_q;

   logic [OP_WIDTH-1:0]   op_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0] a_arr  [NUM_REQ];
   logic [DATA_WIDTH-1:0] b_arr  [NUM_REQ];

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign op_arr[g] = req_op_i[g*OP_WIDTH +: OP_WIDTH];
      assign a_arr[g]  = req_a_i[g*DATA_WIDTH +: DATA_WIDTH];
      assign b_arr[g]  = req_b_i[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IdxW    (IdxW)
   ) u_arb (
      .req_i     (req_valid_i),
      .ptr_i     (rr_ptr_q),
      .gnt_o     (gnt),
      .gnt_idx_o (gnt_idx),
      .gnt_any_o (gnt_any)
   );

   // Driven only from captured registers, so the result cannot move during RESP.
   alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .OP_WIDTH   (OP_WIDTH)
   ) u_alu (
      .alu_op_i (op_q),
      .a_i      (a_q),
      .b_i      (b_q),
      .result_o (alu_result),
      .flag_o   (alu_flag)
   );

   assign capture  = (state_q == StIdle) && gnt_any;
   assign rsp_fire = (state_q == StResp) && rsp_ready_i[owner_q];
   assign next_ptr = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + IdxW'(1);

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (gnt_any) state_d = StExec;
         StExec:  state_d = StResp;
         StResp:  if (rsp_fire) state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Grant is Mealy; masked by reset so nothing looks accepted while held in reset.
   always_comb begin
      req_ready_o = '0;
      rsp_valid_o = '0;
      busy_o      = 1'b0;
      unique case (state_q)
         StIdle: req_ready_o = gnt & {NUM_REQ{arstn_i}};
         StExec: busy_o = 1'b1;
         StResp: begin
            busy_o               = 1'b1;
            rsp_valid_o[owner_q] = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge arstn_i) begin
      if (!arstn_i) begin
         op_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         owner_q    <= '0;
         rr_ptr_q   <= '0;
         result_q   <= '0;
         flag_q     <= 1'b0;
         done_cnt_q <= '0;
      end else begin
         if (capture) begin
            op_q    <= op_arr[gnt_idx];
            a_q     <= a_arr[gnt_idx];
            b_q     <= b_arr[gnt_idx];
            owner_q <= gnt_idx;
         end
         if (state_q == StExec) begin
            result_q <= alu_result;
            flag_q   <= alu_flag;
         end
         if (rsp_fire) begin
            done_cnt_q <= done_cnt_q + DoneCntW'(1);
            rr_ptr_q   <= next_ptr;
         end
      end
   end

   assign rsp_result_o = result_q;
   assign rsp_flag_o   = flag_q;
   assign done_cnt_o   = done_cnt_q;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Scoreboard bench for alu_rr_scheduler: grants push expected responses, handshakes pop them.
module tb_alu_rr_scheduler;
   import alu_opcodes_pkg::*;

   logic         clk = 1'b0;
   logic         arstn;
   logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [19:0]  req_op;
   logic [127:0] req_a, req_b;
   logic [31:0]  rsp_result;
   logic         rsp_flag, busy;
   logic [15:0]  done_cnt;

   logic [4:0]  op_arr [4];
   logic [31:0] a_arr  [4];
   logic [31:0] b_arr  [4];

   typedef struct packed {
      logic [1:0]  owner;
      logic [31:0] res;
      logic        flag;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [1:0]  exp_ptr = 2'd0;
   logic [15:0] exp_done = 16'd0;

   assign req_op = {op_arr[3], op_arr[2], op_arr[1], op_arr[0]};
   assign req_a  = {a_arr[3], a_arr[2], a_arr[1], a_arr[0]};
   assign req_b  = {b_arr[3], b_arr[2], b_arr[1], b_arr[0]};

   always #5 clk = ~clk;

   alu_rr_scheduler dut (
      .clk_i        (clk),
      .arstn_i      (arstn),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_op_i     (req_op),
      .req_a_i      (req_a),
      .req_b_i      (req_b),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_result_o (rsp_result),
      .rsp_flag_o   (rsp_flag),
      .busy_o       (busy),
      .done_cnt_o   (done_cnt)
   );

   function automatic logic [32:0] alu_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      logic [31:0] r;
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_AND:  r = a & b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_SLL:  r = a << b[4:0];
         ALU_SRL:  r = a >> b[4:0];
         ALU_SRA:  r = $signed(a) >>> b[4:0];
         ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU: r = {31'd0, a < b};
         default:  r = 32'd0;
      endcase
      return {(r == 32'd0), r};
   endfunction

   function automatic logic [1:0] rr_pick(input logic [3:0] v, input logic [1:0] ptr);
      logic [1:0] k;
      for (int i = 0; i < 4; i++) begin
         k = ptr + 2'(i);
         if (v[k]) return k;
      end
      return ptr;
   endfunction

   function automatic exp_t exp_for(input logic [1:0] k);
      logic [32:0] m;
      exp_t        e;
      m       = alu_model(op_arr[k], a_arr[k], b_arr[k]);
      e.owner = k;
      e.res   = m[31:0];
      e.flag  = m[32];
      return e;
   endfunction

   task automatic set_req(input logic [1:0] k, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      op_arr[k] = op;
      a_arr[k]  = a;
      b_arr[k]  = b;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      req_valid = 4'b1111;
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
      checks++; if (rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt: got %h want 0000", done_cnt); end
      checks++; if (rsp_result !== 32'd0 || rsp_flag !== 1'b0) begin errors++; $display("FAIL reset_result: got %h/%b want 0/0", rsp_result, rsp_flag); end
      @(negedge clk);
      req_valid = 4'b0000;
      arstn     = 1'b1;
   endtask

   task automatic test_single();
      exp_t e;
      @(negedge clk);
      set_req(2'd0, ALU_ADD, 32'd7, 32'd5);
      req_valid = 4'b0001;
      rsp_ready = 4'b1111;
      #1;
      checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b want 0001", req_ready); end
      sb.push_back(exp_for(2'd0));
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL single_exec: got valid %b busy %b want 0000 1", rsp_valid, busy); end
      @(negedge clk);
      #1;
      e = sb.pop_front();
      checks++; if (rsp_valid !== 4'b0001 || rsp_result !== e.res || rsp_flag !== e.flag) begin errors++; $display("FAIL single_rsp: got %b %h %b want 0001 %h %b", rsp_valid, rsp_result, rsp_flag, e.res, e.flag); end
      checks++; if (rsp_result !== 32'd12) begin errors++; $display("FAIL single_sum: got %0d want 12", rsp_result); end
      exp_ptr = e.owner + 2'd1;
      exp_done++;
      @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0 || done_cnt !== exp_done) begin errors++; $display("FAIL single_done: got busy %b cnt %h want 0 %h", busy, done_cnt, exp_done); end
   endtask

   task automatic test_backpressure();
      exp_t e;
      @(negedge clk);
      set_req(2'd2, ALU_SUB, 32'd3, 32'd5);
      set_req(2'd0, ALU_ADD, 32'd10, 32'd20);
      req_valid = 4'b0100;
      rsp_ready = 4'b0000;
      #1;
      checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_grant: got %b want 0100", req_ready); end
      sb.push_back(exp_for(2'd2));
      @(negedge clk);
      req_valid = 4'b0001;   // another client waits while busy
      rsp_ready = 4'b1011;   // non-owners ready, owner not
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_exec_ready: got %b want 0000", req_ready); end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         #1;
         checks++;
         if (rsp_valid !== 4'b0100 || rsp_result !== 32'hFFFF_FFFE || req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold: cycle %0d got %b %h %b want 0100 fffffffe 0000", c, rsp_valid, rsp_result, req_ready);
         end
      end
      @(negedge clk);
      rsp_ready = 4'b0100;
      #1;
      e = sb.pop_front();
      checks++; if (rsp_valid !== 4'b0100 || rsp_result !== e.res || rsp_flag !== e.flag) begin errors++; $display("FAIL bp_rsp: got %b %h %b want 0100 %h %b", rsp_valid, rsp_result, rsp_flag, e.res, e.flag); end
      exp_ptr = e.owner + 2'd1;
      exp_done++;
      @(negedge clk);
      rsp_ready = 4'b1111;
      #1;
      checks++; if (req_ready !== (4'b0001 << rr_pick(req_valid, exp_ptr))) begin errors++; $display("FAIL bp_next_grant: got %b want 0001", req_ready); end
      sb.push_back(exp_for(rr_pick(req_valid, exp_ptr)));
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      @(negedge clk);
      #1;
      e = sb.pop_front();
      checks++; if (rsp_valid !== (4'b0001 << e.owner) || rsp_result !== e.res || rsp_flag !== e.flag) begin errors++; $display("FAIL bp_second_rsp: got %b %h want owner %0d %h", rsp_valid, rsp_result, e.owner, e.res); end
      exp_ptr = e.owner + 2'd1;
      exp_done++;
      @(negedge clk);
      #1;
      checks++; if (busy !== 1'b0 || done_cnt !== exp_done) begin errors++; $display("FAIL bp_done: got busy %b cnt %h want 0 %h", busy, done_cnt, exp_done); end
   endtask

   task automatic test_reset_mid_op();
      exp_t e;
      int   n;
      @(negedge clk);
      set_req(2'd1, ALU_ADD, 32'd1, 32'd1);
      req_valid = 4'b0010;
      #1;
      checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rst_pre_grant: got %b want 0010", req_ready); end
      @(negedge clk);
      set_req(2'd3, ALU_XOR, 32'h0000_F0F0, 32'h0000_FF00);
      req_valid = 4'b1000;
      arstn     = 1'b0;
      #1;
      checks++; if (req_ready !== 4'b0000 || rsp_valid !== 4'b0000 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_ctrl: got %b %b %b want 0000 0000 0", req_ready, rsp_valid, busy); end
      checks++; if (done_cnt !== 16'd0 || rsp_result !== 32'd0 || rsp_flag !== 1'b0) begin errors++; $display("FAIL rst_mid_data: got %h %h %b want 0 0 0", done_cnt, rsp_result, rsp_flag); end
      @(negedge clk);
      arstn = 1'b1;
      sb.delete();
      exp_ptr  = 2'd0;
      exp_done = 16'd0;
      #1;
      checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL rst_post_grant: got %b want 1000", req_ready); end
      sb.push_back(exp_for(2'd3));
      @(negedge clk);
      req_valid = 4'b0000;
      #1;
      n = 0;
      while (rsp_valid === 4'b0000 && n < 10) begin
         @(negedge clk);
         #1;
         n++;
      end
      checks++;
      if (rsp_valid === 4'b0000) begin
         errors++; $display("FAIL rst_post_timeout: got no response want response");
      end else begin
         e = sb.pop_front();
         if (rsp_valid !== 4'b1000 || rsp_result !== e.res || rsp_flag !== e.flag) begin errors++; $display("FAIL rst_post_rsp: got %b %h want 1000 %h", rsp_valid, rsp_result, e.res); end
         exp_ptr = e.owner + 2'd1;
         exp_done++;
      end
      @(negedge clk);
      #1;
      checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL rst_post_done: got %h want %h", done_cnt, exp_done); end
   endtask

   task automatic test_round_robin();
      exp_t       e;
      logic [1:0] pick;
      int         grants = 0, resps = 0, cyc = 0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) set_req(2'(k), ALU_ADD, 32'(k), 32'd1);
      req_valid = 4'b1111;
      rsp_ready = 4'b1111;
      #1;
      while (resps < 5 && cyc < 60) begin
         if (req_ready !== 4'b0000) begin
            pick = rr_pick(req_valid, exp_ptr);
            checks++; if (req_ready !== (4'b0001 << pick)) begin errors++; $display("FAIL rr_grant: got %b want owner %0d", req_ready, pick); end
            sb.push_back(exp_for(pick));
            grants++;
         end
         if (rsp_valid !== 4'b0000) begin
            e = sb.pop_front();
            checks++; if (rsp_valid !== (4'b0001 << e.owner) || rsp_result !== e.res || rsp_flag !== e.flag) begin errors++; $display("FAIL rr_rsp: got %b %h want owner %0d %h", rsp_valid, rsp_result, e.owner, e.res); end
            exp_ptr = e.owner + 2'd1;
            exp_done++;
            resps++;
         end
         @(negedge clk);
         if (grants >= 5) req_valid = 4'b0000;
         #1;
         cyc++;
      end
      checks++; if (resps != 5) begin errors++; $display("FAIL rr_count: got %0d responses want 5", resps); end
      checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL rr_done: got %h want %h", done_cnt, exp_done); end
   endtask

   task automatic test_withdrawn();
      exp_t       e;
      logic [1:0] pick;
      int         grants = 1, resps = 0, cyc = 0;
      @(negedge clk);
      for (int k = 0; k < 4; k++) set_req(2'(k), ALU_ADD, 32'(10 * k), 32'd3);
      req_valid = 4'b0101;
      #1;
      pick = rr_pick(req_valid, exp_ptr);
      checks++; if (req_ready !== (4'b0001 << pick)) begin errors++; $display("FAIL wd_first: got %b want owner %0d", req_ready, pick); end
      sb.push_back(exp_for(pick));
      @(negedge clk);
      req_valid = 4'b0111;   // requester 1 pulses while busy
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL wd_pulse: got %b want 0000", req_ready); end
      @(negedge clk);
      req_valid = 4'b0101;
      #1;
      while (resps < 4 && cyc < 60) begin
         if (req_ready !== 4'b0000) begin
            pick = rr_pick(req_valid, exp_ptr);
            checks++; if (req_ready !== (4'b0001 << pick)) begin errors++; $display("FAIL wd_grant: got %b want owner %0d", req_ready, pick); end
            sb.push_back(exp_for(pick));
            grants++;
         end
         if (rsp_valid !== 4'b0000) begin
            e = sb.pop_front();
            checks++; if (rsp_valid !== (4'b0001 << e.owner) || rsp_result !== e.res || rsp_flag !== e.flag) begin errors++; $display("FAIL wd_rsp: got %b %h want owner %0d %h", rsp_valid, rsp_result, e.owner, e.res); end
            exp_ptr = e.owner + 2'd1;
            exp_done++;
            resps++;
         end
         @(negedge clk);
         if (grants >= 4) req_valid = 4'b0000;
         #1;
         cyc++;
      end
      checks++; if (resps != 4) begin errors++; $display("FAIL wd_count: got %0d responses want 4", resps); end
      checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL wd_done: got %h want %h", done_cnt, exp_done); end
   endtask

   task automatic test_counter_wrap();
      exp_t e;
      int   n;
      @(negedge clk);
      force dut.done_cnt_q = 16'hFFFD;
      #1;
      release dut.done_cnt_q;
      exp_done = 16'hFFFD;
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         set_req(2'd0, ALU_SLL, 32'd1, 32'(t));
         req_valid = 4'b0001;
         rsp_ready = 4'b1111;
         #1;
         checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b want 0001", req_ready); end
         sb.push_back(exp_for(2'd0));
         @(negedge clk);
         req_valid = 4'b0000;
         #1;
         n = 0;
         while (rsp_valid === 4'b0000 && n < 10) begin
            @(negedge clk);
            #1;
            n++;
         end
         checks++;
         if (rsp_valid === 4'b0000) begin
            errors++; $display("FAIL wrap_timeout: got no response want response");
            sb.delete();
         end else begin
            e = sb.pop_front();
            if (rsp_valid !== 4'b0001 || rsp_result !== e.res) begin errors++; $display("FAIL wrap_rsp: got %b %h want 0001 %h", rsp_valid, rsp_result, e.res); end
            exp_ptr = e.owner + 2'd1;
            exp_done++;
         end
         @(negedge clk);
         #1;
         checks++; if (done_cnt !== exp_done) begin errors++; $display("FAIL wrap_cnt: got %h want %h", done_cnt, exp_done); end
      end
      checks++; if (done_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h want 0000", done_cnt); end
   endtask

   initial begin
      arstn     = 1'b1;
      req_valid = 4'b0000;
      rsp_ready = 4'b0000;
      for (int k = 0; k < 4; k++) set_req(2'(k), 5'd0, 32'd0, 32'd0);
      #2 arstn = 1'b0;
      test_reset();
      test_single();
      test_backpressure();
      test_reset_mid_op();
      test_round_robin();
      test_withdrawn();
      test_counter_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

endmodule
